// File: rtl/mem_wb_stage_pkg.sv
// mips_pkg: shared widths, constants and FSM state type for the MEM/WB stage
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W = 5;
   localparam int WB_W = 2;
   localparam int TIMEOUT_MAX = 15;
   localparam logic [DATA_W-1:0] BUBBLE_DATA = 32'hDEADBEEF;
   typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory request/acknowledge port of the MEM/WB stage
interface mem_wb_stage_if;
   import mips_pkg::*;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;
   modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata);
   modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_reg: MEM/WB pipeline registers with independent wb/valid, field and read-data loads
module mem_wb_reg import mips_pkg::*; (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_wb,
   input  logic              ld_fields,
   input  logic              ld_rd,
   input  logic [WB_W-1:0]   wb_nxt,
   input  logic              valid_nxt,
   input  logic [DATA_W-1:0] rd_nxt,
   input  logic [DATA_W-1:0] alu_nxt,
   input  logic [REG_W-1:0]  wr_nxt,
   output logic [WB_W-1:0]   wb_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [REG_W-1:0]  writereg_out
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_out <= '0;
         valid_out <= 1'b0;
         read_data_out <= '0;
         alu_out <= '0;
         writereg_out <= '0;
      end else begin
         if (ld_wb) begin
            wb_out <= wb_nxt;
            valid_out <= valid_nxt;
         end
         if (ld_fields) begin
            alu_out <= alu_nxt;
            writereg_out <= wr_nxt;
         end
         if (ld_rd) read_data_out <= rd_nxt;
      end
   end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with data-memory handshake FSM feeding MEM/WB; MEM_TIMEOUT_EN adds err/timeout
module mem_wb_stage import mips_pkg::*; (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [DATA_W-1:0] pc,
   input  logic [WB_W-1:0]   wb,
   input  logic              memwrite,
   input  logic              memread,
   input  logic              branch,
   input  logic              zero,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [REG_W-1:0]  writereg,
   mem_wb_stage_if.master    mem,
   output logic              stall,
   output logic              pcsrc,
   output logic [DATA_W-1:0] branch_pc,
   output logic [WB_W-1:0]   wb_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [REG_W-1:0]  writereg_out,
   output logic              valid_out
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              err
`endif
);
   state_t state, state_nxt;
   logic [WB_W-1:0] wb_h;
   logic [REG_W-1:0] wr_h;
   logic launch, pass, done, tmo;
   assign pcsrc = branch & zero & ce;
   assign branch_pc = pc;
   assign mem.dmem_req = state == ACCESS;
   assign launch = state == IDLE && ce && (memread || memwrite);
   assign pass = state == IDLE && ce && !(memread || memwrite);
   assign done = state == ACCESS && mem.dmem_ack;
   assign stall = launch || state == ACCESS;
`ifdef MEM_TIMEOUT_EN
   logic [3:0] cnt;
   // fires on the edge that would bring the counter to TIMEOUT_MAX
   assign tmo = state == ACCESS && !mem.dmem_ack && cnt == 4'(TIMEOUT_MAX - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (launch) cnt <= '0;
         else if (state == ACCESS && !mem.dmem_ack) cnt <= cnt + 4'd1;
         if (tmo) err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif
   always_comb state_nxt = launch ? ACCESS : (done || tmo) ? IDLE : state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mem.dmem_we <= 1'b0;
         mem.dmem_addr <= '0;
         mem.dmem_wdata <= '0;
         wb_h <= '0;
         wr_h <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            mem.dmem_addr <= alu_in;
            mem.dmem_wdata <= rt_data;
            mem.dmem_we <= memwrite;
            wb_h <= wb;
            wr_h <= writereg;
         end
      end
   end
   // stalled cycles without completion load a bubble (wb=00, valid=0)
   mem_wb_reg u_reg (
      .clk(clk),
      .rst_n(rst_n),
      .ld_wb(stall || pass),
      .ld_fields(done || pass),
      .ld_rd((done && !mem.dmem_we) || tmo),
      .wb_nxt(done ? wb_h : pass ? wb : '0),
      .valid_nxt(done || tmo || pass),
      .rd_nxt(tmo ? BUBBLE_DATA : mem.dmem_rdata),
      .alu_nxt(done ? mem.dmem_addr : alu_in),
      .wr_nxt(done ? wr_h : writereg),
      .wb_out(wb_out),
      .valid_out(valid_out),
      .read_data_out(read_data_out),
      .alu_out(alu_out),
      .writereg_out(writereg_out)
   );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage; MEM_TIMEOUT_EN enables the timeout scenario
module tb_mem_wb_stage;
   typedef struct {
      logic [1:0]  wb;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wr;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rd;
   logic clk = 0, rst_n = 0, ce = 0, memwrite = 0, memread = 0, branch = 0, zero = 0;
   logic [31:0] pc = 0, alu_in = 0, rt_data = 0;
   logic [1:0] wb = 0;
   logic [4:0] writereg = 0;
   logic stall, pcsrc, valid_out;
   logic [31:0] branch_pc, read_data_out, alu_out;
   logic [1:0] wb_out;
   logic [4:0] writereg_out;
   mem_wb_stage_if mif();
`ifdef MEM_TIMEOUT_EN
   logic err;
`endif

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .pc(pc), .wb(wb), .memwrite(memwrite), .memread(memread),
      .branch(branch), .zero(zero), .alu_in(alu_in), .rt_data(rt_data), .writereg(writereg),
      .mem(mif.master), .stall(stall), .pcsrc(pcsrc), .branch_pc(branch_pc), .wb_out(wb_out),
      .read_data_out(read_data_out), .alu_out(alu_out), .writereg_out(writereg_out), .valid_out(valid_out)
`ifdef MEM_TIMEOUT_EN
      , .err(err)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      mif.dmem_ack = 0;
      mif.dmem_rdata = 0;
      rst_n = 0;
      step();
      checks++;
      if ({mif.dmem_req, mif.dmem_we, mif.dmem_addr, mif.dmem_wdata, stall} !== '0) begin
         errors++;
         $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h stall=%b want all 0",
                  mif.dmem_req, mif.dmem_we, mif.dmem_addr, mif.dmem_wdata, stall);
      end
      checks++;
      if ({wb_out, valid_out, read_data_out, alu_out, writereg_out} !== '0) begin
         errors++;
         $display("FAIL reset_memwb: got wb=%b v=%b rd=%h alu=%h wr=%0d want all 0",
                  wb_out, valid_out, read_data_out, alu_out, writereg_out);
      end
      rst_n = 1;
      exp_rd = 0;
   endtask

   task automatic test_alu_op();
      ce = 1; wb = 2'b01; alu_in = 32'h10; writereg = 5'd3;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %b want 0", stall); end
      q.push_back('{wb: 2'b01, rd: exp_rd, alu: 32'h10, wr: 5'd3});
      step();
      checks++;
      if (valid_out !== 1'b1 || stall !== 1'b0) begin
         errors++; $display("FAIL alu_valid: got valid=%b stall=%b want 1 0", valid_out, stall);
      end
      e = q.pop_front();
      checks++;
      if ({wb_out, read_data_out, alu_out, writereg_out} !== {e.wb, e.rd, e.alu, e.wr}) begin
         errors++;
         $display("FAIL alu_data: got wb=%b rd=%h alu=%h wr=%0d want wb=%b rd=%h alu=%h wr=%0d",
                  wb_out, read_data_out, alu_out, writereg_out, e.wb, e.rd, e.alu, e.wr);
      end
      ce = 0; alu_in = 32'h99; writereg = 5'd30;
      step();
      checks++;
      if (valid_out !== 1'b1 || alu_out !== 32'h10 || mif.dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL ce0_hold: got valid=%b alu=%h req=%b want 1 00000010 0", valid_out, alu_out, mif.dmem_req);
      end
   endtask

   task automatic test_load();
      int stalls = 0;
      ce = 1; memread = 1; alu_in = 32'h40; wb = 2'b11; writereg = 5'd7;
      mif.dmem_rdata = 32'hCAFEF00D;
      q.push_back('{wb: 2'b11, rd: 32'hCAFEF00D, alu: 32'h40, wr: 5'd7});
      exp_rd = 32'hCAFEF00D;
      #1;
      if (stall) stalls++;
      step();
      ce = 0; memread = 0; alu_in = 0;
      checks++;
      if (mif.dmem_req !== 1'b1 || mif.dmem_addr !== 32'h40 || mif.dmem_we !== 1'b0) begin
         errors++;
         $display("FAIL load_launch: got req=%b addr=%h we=%b want 1 00000040 0", mif.dmem_req, mif.dmem_addr, mif.dmem_we);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (valid_out !== 1'b0 || wb_out !== 2'b00) begin
            errors++; $display("FAIL load_bubble%0d: got valid=%b wb=%b want 0 00", i, valid_out, wb_out);
         end
         mif.dmem_ack = (i == 2);
         #1;
         if (stall) stalls++;
         step();
      end
      mif.dmem_ack = 0;
      checks++;
      if (stalls !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d want 4", stalls); end
      checks++;
      if (mif.dmem_req !== 1'b0 || stall !== 1'b0 || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL load_done: got req=%b stall=%b valid=%b want 0 0 1", mif.dmem_req, stall, valid_out);
      end
      e = q.pop_front();
      checks++;
      if ({wb_out, read_data_out, alu_out, writereg_out} !== {e.wb, e.rd, e.alu, e.wr}) begin
         errors++;
         $display("FAIL load_data: got wb=%b rd=%h alu=%h wr=%0d want wb=%b rd=%h alu=%h wr=%0d",
                  wb_out, read_data_out, alu_out, writereg_out, e.wb, e.rd, e.alu, e.wr);
      end
   endtask

   task automatic test_store();
      mif.dmem_ack = 1;
      step();
      mif.dmem_ack = 0;
      checks++;
      if (mif.dmem_req !== 1'b0 || valid_out !== 1'b1 || read_data_out !== exp_rd) begin
         errors++;
         $display("FAIL idle_ack: got req=%b valid=%b rd=%h want 0 1 %h", mif.dmem_req, valid_out, read_data_out, exp_rd);
      end
      ce = 1; memwrite = 1; memread = 1; rt_data = 32'h1234; alu_in = 32'h80; wb = 2'b01; writereg = 5'd9;
      q.push_back('{wb: 2'b01, rd: exp_rd, alu: 32'h80, wr: 5'd9});
      step();
      ce = 0; memwrite = 0; memread = 0; rt_data = 0;
      checks++;
      if (mif.dmem_req !== 1'b1 || mif.dmem_we !== 1'b1 || mif.dmem_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL store_launch: got req=%b we=%b wdata=%h want 1 1 00001234", mif.dmem_req, mif.dmem_we, mif.dmem_wdata);
      end
      mif.dmem_ack = 1; mif.dmem_rdata = 32'h55555555;
      step();
      mif.dmem_ack = 0;
      e = q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || {wb_out, read_data_out, alu_out, writereg_out} !== {e.wb, e.rd, e.alu, e.wr}) begin
         errors++;
         $display("FAIL store_data: got v=%b wb=%b rd=%h alu=%h wr=%0d want v=1 wb=%b rd=%h alu=%h wr=%0d",
                  valid_out, wb_out, read_data_out, alu_out, writereg_out, e.wb, e.rd, e.alu, e.wr);
      end
   endtask

   task automatic test_branch();
      ce = 1; branch = 1; zero = 1; pc = 32'h100;
      #1;
      checks++;
      if (pcsrc !== 1'b1 || branch_pc !== 32'h100) begin
         errors++; $display("FAIL branch_taken: got pcsrc=%b pc=%h want 1 00000100", pcsrc, branch_pc);
      end
      ce = 0;
      #1;
      checks++;
      if (pcsrc !== 1'b0) begin errors++; $display("FAIL branch_ce0: got %b want 0", pcsrc); end
      ce = 1; zero = 0;
      #1;
      checks++;
      if (pcsrc !== 1'b0) begin errors++; $display("FAIL branch_nz: got %b want 0", pcsrc); end
      ce = 0; branch = 0;
   endtask

   task automatic test_back_to_back();
      ce = 1;
      for (int i = 0; i < 6; i++) begin
         wb = 2'($urandom_range(3)); alu_in = $urandom; writereg = 5'($urandom_range(31));
         q.push_back('{wb: wb, rd: exp_rd, alu: alu_in, wr: writereg});
         step();
         e = q.pop_front();
         checks++;
         if (valid_out !== 1'b1 || {wb_out, read_data_out, alu_out, writereg_out} !== {e.wb, e.rd, e.alu, e.wr}) begin
            errors++;
            $display("FAIL b2b%0d: got v=%b wb=%b rd=%h alu=%h wr=%0d want v=1 wb=%b rd=%h alu=%h wr=%0d",
                     i, valid_out, wb_out, read_data_out, alu_out, writereg_out, e.wb, e.rd, e.alu, e.wr);
         end
      end
      ce = 0;
   endtask

   task automatic test_reset_mid();
      ce = 1; memread = 1; alu_in = 32'h200;
      step();
      ce = 0; memread = 0;
      step();
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({mif.dmem_req, stall, mif.dmem_addr, wb_out, valid_out, read_data_out, alu_out, writereg_out} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got req=%b stall=%b addr=%h wb=%b v=%b rd=%h alu=%h wr=%0d want all 0",
                  mif.dmem_req, stall, mif.dmem_addr, wb_out, valid_out, read_data_out, alu_out, writereg_out);
      end
      step();
      rst_n = 1;
      mif.dmem_ack = 1; mif.dmem_rdata = 32'h77777777;
      step();
      mif.dmem_ack = 0;
      checks++;
      if (mif.dmem_req !== 1'b0 || valid_out !== 1'b0 || read_data_out !== 32'h0) begin
         errors++;
         $display("FAIL late_ack: got req=%b valid=%b rd=%h want 0 0 00000000", mif.dmem_req, valid_out, read_data_out);
      end
      exp_rd = 0;
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int reqs = 0;
      ce = 1; memread = 1; alu_in = 32'h300; wb = 2'b11; writereg = 5'd4;
      step();
      ce = 0; memread = 0;
      for (int i = 0; i < 40 && mif.dmem_req; i++) begin
         reqs++;
         step();
      end
      checks++;
      if (reqs !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", reqs); end
      checks++;
      if (err !== 1'b1 || read_data_out !== 32'hDEADBEEF || wb_out !== 2'b00 || valid_out !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL timeout_out: got err=%b rd=%h wb=%b v=%b stall=%b want 1 deadbeef 00 1 0",
                  err, read_data_out, wb_out, valid_out, stall);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu_op();
      test_load();
      test_store();
      test_branch();
      test_back_to_back();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
